// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word, opcode encoding, and the
// fetch-stage state and IF/ID register layout.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  // Fetch-stage controller states.
  //   S_IDLE   : one cycle after reset before the first request
  //   S_REQ    : read outstanding at pc
  //   S_BUF    : a fetched word is parked in the skid buffer, no read
  //   S_SQUASH : a read whose data will be thrown away is still in flight
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_BUF    = 2'd2,
    S_SQUASH = 2'd3
  } lc3b_fetch_state;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic     valid;
    lc3b_word pc;
    lc3b_word ir;
  } lc3b_ifid_reg;

  // Instruction addresses are halfword aligned; bit 0 is always dropped.
  function automatic lc3b_word align_pc(input lc3b_word addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/lc3b_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and the
// instruction memory (slave).
interface lc3b_fetch_stage_if;
  import lc3b_types::*;

  logic     read;     // request, held until resp
  lc3b_word address;  // fetch address, stable while read=1
  lc3b_word rdata;    // instruction word, valid with resp
  logic     resp;     // single-cycle completion pulse

  modport master (
    output read,
    output address,
    input  rdata,
    input  resp
  );

  modport slave (
    input  read,
    input  address,
    output rdata,
    output resp
  );

endinterface

// File: rtl/ifid_skid_buffer.sv
// One-entry holding register for a fetched {pc, ir} pair that arrived while
// the IF/ID register was stalled. Clear wins over load, load over drain.
module ifid_skid_buffer
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     drain,
  input  logic     clear,
  input  lc3b_word load_pc,
  input  lc3b_word load_ir,
  output logic     full,
  output lc3b_word entry_pc,
  output lc3b_word entry_ir
);

  logic     full_reg;
  lc3b_word pc_reg;
  lc3b_word ir_reg;

  // Occupancy flag: a redirect flush empties the entry regardless of load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg <= 1'b1;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  // Payload captured only on load; contents are don't-care while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
      ir_reg <= '0;
    end else if (load && !clear) begin
      pc_reg <= load_pc;
      ir_reg <= load_ir;
    end
  end

  assign full     = full_reg;
  assign entry_pc = pc_reg;
  assign entry_ir = ir_reg;

endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b pipeline IF stage: owns the PC, drives the instruction-memory read
// handshake, and fills the IF/ID register. A one-entry skid buffer absorbs a
// response that lands while decode is stalled; redirects flush IF/ID and the
// buffer, and a read already in flight is allowed to finish and discarded.
module lc3b_fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word PC_STEP  = 16'h0002
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lc3b_fetch_stage_if.master        imem,
  input  logic                      stall_in,
  input  logic                      redirect_valid,
  input  lc3b_word                  redirect_pc,
  output logic                      ifid_valid,
  output lc3b_word                  ifid_ir,
  output lc3b_word                  ifid_pc,
  output lc3b_opcode                ifid_opcode,
  output logic                      ifid_imm_check
);

  localparam lc3b_word START_PC = RESET_PC & 16'hFFFE;

  lc3b_fetch_state state_reg, state_next;
  lc3b_word        pc_reg, pc_next;
  // Where to resume once a squashed read completes. pc_reg keeps the
  // squashed address meanwhile so the bus address stays stable.
  lc3b_word        target_reg, target_next;
  lc3b_ifid_reg    ifid_reg, ifid_next;

  lc3b_word pc_plus_step;
  lc3b_word redirect_target;
  logic     ifid_free;

  logic     buf_load;
  logic     buf_drain;
  logic     buf_clear;
  logic     buf_full;
  lc3b_word buf_pc;
  lc3b_word buf_ir;

  assign pc_plus_step    = pc_reg + PC_STEP;
  assign redirect_target = align_pc(redirect_pc);
  // A bubble never blocks: IF/ID can take a new value unless it holds a live
  // instruction that decode is refusing.
  assign ifid_free       = !stall_in || !ifid_reg.valid;

  ifid_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .drain    (buf_drain),
    .clear    (buf_clear),
    .load_pc  (pc_plus_step),
    .load_ir  (imem.rdata),
    .full     (buf_full),
    .entry_pc (buf_pc),
    .entry_ir (buf_ir)
  );

  // State, PC, redirect target and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      pc_reg     <= START_PC;
      target_reg <= START_PC;
      ifid_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      ifid_reg   <= ifid_next;
    end
  end

  // Next-state, PC update, IF/ID load and skid-buffer control.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    ifid_next   = ifid_reg;
    buf_load    = 1'b0;
    buf_drain   = 1'b0;
    buf_clear   = 1'b0;

    // When IF/ID is free and nothing is loaded below, it becomes a bubble.
    if (ifid_free) begin
      ifid_next.valid = 1'b0;
    end

    if (redirect_valid) begin
      // Redirect beats both stall and a coincident response.
      ifid_next.valid = 1'b0;
      buf_clear       = 1'b1;
      case (state_reg)
        S_IDLE: begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end
        S_REQ: begin
          if (imem.resp) begin
            // The read just finished: drop its data, fetch target next cycle.
            pc_next = redirect_target;
          end else begin
            // Read still pending: let it complete on the old address.
            target_next = redirect_target;
            state_next  = S_SQUASH;
          end
        end
        S_BUF: begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end
        S_SQUASH: begin
          if (imem.resp) begin
            // Stale read ends on this edge, so go straight to the newest target.
            pc_next    = redirect_target;
            state_next = S_REQ;
          end else begin
            target_next = redirect_target;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_REQ;
        end
        S_REQ: begin
          if (imem.resp) begin
            pc_next = pc_plus_step;
            if (ifid_free) begin
              ifid_next.valid = 1'b1;
              ifid_next.pc    = pc_plus_step;
              ifid_next.ir    = imem.rdata;
            end else begin
              buf_load   = 1'b1;
              state_next = S_BUF;
            end
          end
        end
        S_BUF: begin
          if (ifid_free) begin
            if (buf_full) begin
              ifid_next.valid = 1'b1;
              ifid_next.pc    = buf_pc;
              ifid_next.ir    = buf_ir;
            end
            buf_drain  = 1'b1;
            state_next = S_REQ;
          end
        end
        S_SQUASH: begin
          if (imem.resp) begin
            pc_next    = target_reg;
            state_next = S_REQ;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Bus outputs depend only on registered state and pc.
  assign imem.read    = (state_reg == S_REQ) || (state_reg == S_SQUASH);
  assign imem.address = pc_reg;

  assign ifid_valid     = ifid_reg.valid;
  assign ifid_ir        = ifid_reg.ir;
  assign ifid_pc        = ifid_reg.pc;
  assign ifid_opcode    = lc3b_opcode'(ifid_reg.ir[15:12]);
  assign ifid_imm_check = ifid_reg.ir[5];

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Bench for lc3b_fetch_stage: memory model with configurable latency, a
// scoreboard of the architecturally expected instruction stream, and a
// directed-then-random stimulus sequence.
module tb_lc3b_fetch_stage;
  import lc3b_types::*;

  localparam lc3b_word RESET_PC = 16'h0000;
  localparam lc3b_word PC_STEP  = 16'h0002;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall_in = 1'b0;
  logic       redirect_valid = 1'b0;
  lc3b_word   redirect_pc = 16'h0000;
  logic       ifid_valid;
  lc3b_word   ifid_ir;
  lc3b_word   ifid_pc;
  lc3b_opcode ifid_opcode;
  logic       ifid_imm_check;

  lc3b_fetch_stage_if imem_bus ();

  lc3b_fetch_stage #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_ir        (ifid_ir),
    .ifid_pc        (ifid_pc),
    .ifid_opcode    (ifid_opcode),
    .ifid_imm_check (ifid_imm_check)
  );

  always #5 clk = ~clk;

  typedef struct {
    lc3b_word pc;
    lc3b_word ir;
  } exp_t;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int lat_fixed = 0;          // <0: random latency 0..3 per read

  lc3b_word mem [32768];

  // Scoreboard: the consumed stream is sequential from the last redirect
  // target (or reset PC); IR is the memory word at the instruction address.
  exp_t     exp_q [$];
  lc3b_word fill_pc;

  // Memory / address-model state.
  logic     in_txn;
  logic     txn_squashed;
  lc3b_word txn_addr;
  int       cnt;
  lc3b_word fetch_ptr;
  logic     e_resp, e_redir;
  lc3b_word e_tgt;
  logic     seen_resp;
  logic     hold_pending;
  lc3b_word hold_ir, hold_pc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    imem_bus.resp  = 1'b0;
    in_txn         = 1'b0;
    txn_squashed   = 1'b0;
    cnt            = 0;
    fetch_ptr      = RESET_PC & 16'hFFFE;
    e_resp         = 1'b0;
    e_redir        = 1'b0;
    e_tgt          = 16'h0000;
    seen_resp      = 1'b0;
    hold_pending   = 1'b0;
    exp_q.delete();
    fill_pc        = RESET_PC & 16'hFFFE;
  endtask

  // Runs 1 ns after each rising edge: account for what happened at the edge,
  // then present this cycle's memory response.
  task automatic mem_step();
    if (e_resp) begin
      in_txn = 1'b0;
      if (!txn_squashed && !e_redir) fetch_ptr = fetch_ptr + PC_STEP;
      txn_squashed = 1'b0;
    end
    if (e_redir) begin
      fetch_ptr = e_tgt & 16'hFFFE;
      if (in_txn) txn_squashed = 1'b1;
    end
    e_resp  = 1'b0;
    e_redir = 1'b0;
    imem_bus.resp = 1'b0;
    if (imem_bus.read) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        txn_addr = imem_bus.address;
        cnt      = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
        check("fetch_addr", imem_bus.address, fetch_ptr);
      end else begin
        check("addr_stable", imem_bus.address, txn_addr);
      end
      if (cnt == 0) begin
        imem_bus.resp  = 1'b1;
        imem_bus.rdata = mem[imem_bus.address[15:1]];
      end else begin
        cnt--;
      end
    end else begin
      if (in_txn) begin
        total++;
        bad++;
        $display("FAIL read_held: read dropped at %h before resp at %0t", txn_addr, $time);
        in_txn = 1'b0;
      end
      // Stray response with no request outstanding must be ignored.
      if ($urandom_range(0, 7) == 0) begin
        imem_bus.resp  = 1'b1;
        imem_bus.rdata = 16'($urandom);
      end
    end
  endtask

  // Runs 2 ns before each rising edge, when inputs and outputs are settled.
  task automatic monitor_step();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.pc = fill_pc + PC_STEP;
      e.ir = mem[fill_pc[15:1]];
      exp_q.push_back(e);
      fill_pc = fill_pc + PC_STEP;
    end
    if (!seen_resp) check("early_valid", 16'(ifid_valid), 16'h0);
    if (hold_pending) begin
      check("hold_valid", 16'(ifid_valid), 16'h1);
      check("hold_ir", ifid_ir, hold_ir);
      check("hold_pc", ifid_pc, hold_pc);
    end
    hold_pending = ifid_valid && stall_in && !redirect_valid;
    hold_ir      = ifid_ir;
    hold_pc      = ifid_pc;
    if (ifid_valid && !stall_in && !redirect_valid) begin
      e = exp_q.pop_front();
      pops++;
      $display("consume pc=%h ir=%h exp_pc=%h exp_ir=%h", ifid_pc, ifid_ir, e.pc, e.ir);
      check("ifid_pc", ifid_pc, e.pc);
      check("ifid_ir", ifid_ir, e.ir);
      check("ifid_opcode", 16'(ifid_opcode), 16'(e.ir[15:12]));
      check("ifid_imm", 16'(ifid_imm_check), 16'(e.ir[5]));
    end
    if (redirect_valid) begin
      exp_q.delete();
      fill_pc = redirect_pc & 16'hFFFE;
    end
    e_redir = redirect_valid;
    e_tgt   = redirect_pc;
    e_resp  = imem_bus.resp && imem_bus.read;
    if (e_resp) seen_resp = 1'b1;
  endtask

  initial begin : bench_model
    imem_bus.resp  = 1'b0;
    imem_bus.rdata = 16'h0000;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else mem_step();
      #7;
      if (rst_n) monitor_step();
    end
  end

  task automatic do_redirect(input lc3b_word tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    $display("redirect to %h", tgt);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!ifid_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(ifid_valid), 16'h1);
  endtask

  initial begin : stimulus
    int n;
    int held;
    int pops_before;
    logic found;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1261;
    mem[1] = 16'h5042;
    lat_fixed = 0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read", 16'(imem_bus.read), 16'h0);
    check("rst_addr", imem_bus.address, RESET_PC);
    check("rst_valid", 16'(ifid_valid), 16'h0);
    check("rst_ir", ifid_ir, 16'h0000);
    check("rst_pc", ifid_pc, 16'h0000);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Stall with a response arriving: word parks in the buffer
    wait_valid("stall_setup");
    stall_in = 1'b1;
    @(negedge clk);
    check("buf_read", 16'(imem_bus.read), 16'h0);
    repeat (2) @(negedge clk);
    stall_in = 1'b0;
    repeat (6) @(negedge clk);

    // Redirect while a slow read is pending
    lat_fixed = 3;
    do_redirect(16'h0010);
    check("squash_setup", 16'(imem_bus.read && imem_bus.address == 16'h0010), 16'h1);
    do_redirect(16'h0040);
    held = 0;
    n = 0;
    while (n < 20) begin
      check("squash_flush", 16'(ifid_valid), 16'h0);
      if (imem_bus.address == 16'h0040) break;
      if (imem_bus.read && imem_bus.address == 16'h0010) held++;
      @(negedge clk);
      n++;
    end
    check("squash_hold", 16'(held), 16'd3);
    check("squash_target", imem_bus.address, 16'h0040);
    lat_fixed = 0;
    repeat (6) @(negedge clk);

    // Redirect coincident with a response, odd target
    n = 0;
    while (!(imem_bus.resp && imem_bus.read) && n < 20) begin
      @(negedge clk);
      n++;
    end
    do_redirect(16'h0041);
    check("rsp_redir_flush", 16'(ifid_valid), 16'h0);
    check("rsp_redir_addr", imem_bus.address, 16'h0040);
    check("rsp_redir_read", 16'(imem_bus.read), 16'h1);
    repeat (5) @(negedge clk);

    // Redirect while stalled with the buffer full
    wait_valid("stall_redir_setup");
    stall_in = 1'b1;
    repeat (2) @(negedge clk);
    do_redirect(16'h0100);
    check("stall_redir_flush", 16'(ifid_valid), 16'h0);
    check("stall_redir_addr", imem_bus.address, 16'h0100);
    check("stall_redir_read", 16'(imem_bus.read), 16'h1);
    stall_in = 1'b0;
    repeat (5) @(negedge clk);

    // Address wrap at the top of memory
    do_redirect(16'hFFFC);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_bus.read && imem_bus.address == 16'h0000) found = 1'b1;
      @(negedge clk);
    end
    check("wrap_addr", 16'(found), 16'h1);

    // Randomised traffic
    lat_fixed = -1;
    for (int i = 0; i < 1500; i++) begin
      stall_in = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 3) do_redirect(16'($urandom));
      else @(negedge clk);
    end
    stall_in = 1'b0;
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of a read
    lat_fixed = 3;
    n = 0;
    while (!imem_bus.read && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_read", 16'(imem_bus.read), 16'h0);
    check("arst_addr", imem_bus.address, RESET_PC);
    check("arst_valid", 16'(ifid_valid), 16'h0);
    check("arst_ir", ifid_ir, 16'h0000);
    check("arst_pc", ifid_pc, 16'h0000);
    repeat (2) @(negedge clk);
    lat_fixed = 0;
    pops_before = pops;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("restart", 16'(pops > pops_before + 5), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
